multi_channel_sequencer: RTL and testbench

- Time-multiplexed N-channel note sequencer. One shared pattern ROM port and one shared note-table ROM port are used in turn by every channel.
- On each note strobe, the block sweeps channels 0..N-1 in order. Each channel's duration counter is either decremented or, when it expires, the channel fetches its next pattern word and looks up the pitch's phase delta.
- Sits between the timing strobe generator and the per-channel oscillators/mixer.
- Replaces the single-channel controller/sequencer/pitch-lookup/duration chain.

---
 rtl/multi_channel_sequencer.sv | 152 +++++++++++++++
 tb/tb_multi_channel_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multi_channel_sequencer.sv
// multi_channel_sequencer: time-multiplexed N-channel note sequencer sharing one pattern ROM and one note-table ROM
module multi_channel_sequencer #(
  parameter int NUM_CHANNELS = 4,
  parameter int PTR_W = 6,
  parameter int PHASE_W = 16,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_note_stb,
  input  logic                            i_restart,
  input  logic [NUM_CHANNELS-1:0]         i_ch_enable,
  output logic [CH_W+PTR_W-1:0]           o_pat_addr,
  input  logic [15:0]                     i_pat_data,
  output logic [5:0]                      o_note_addr,
  input  logic [PHASE_W-1:0]              i_note_data,
  output logic [NUM_CHANNELS*PHASE_W-1:0] o_phase_delta,
  output logic [NUM_CHANNELS*4-1:0]       o_instrument,
  output logic [NUM_CHANNELS-1:0]         o_gate,
  output logic [NUM_CHANNELS-1:0]         o_load_stb,
  output logic                            o_busy,
  output logic                            o_overrun
);
  typedef enum logic [2:0] {IDLE, CHECK, PAT_REQ, PAT_LATCH, NOTE_REQ, NOTE_LATCH} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [NUM_CHANNELS-1:0][PTR_W-1:0] ptr_q, ptr_d;
  logic [NUM_CHANNELS-1:0][4:0] dur_q, dur_d;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phase_q, phase_d;
  logic [NUM_CHANNELS-1:0][3:0] inst_q, inst_d;
  logic [NUM_CHANNELS-1:0] gate_q, gate_d, load_q, load_d;
  logic busy_q, busy_d, ovr_q, ovr_d;
  logic [CH_W+PTR_W-1:0] pat_addr_q, pat_addr_d;
  logic [5:0] note_addr_q, note_addr_d;
  logic [5:0] pitch;
  logic last_ch, adv;
  assign pitch = i_pat_data[15:10];
  assign last_ch = ch_q == CH_W'(NUM_CHANNELS - 1);
  assign o_pat_addr = pat_addr_q;
  assign o_note_addr = note_addr_q;
  assign o_phase_delta = phase_q;
  assign o_instrument = inst_q;
  assign o_gate = gate_q;
  assign o_load_stb = load_q;
  assign o_busy = busy_q;
  assign o_overrun = ovr_q;
  // Sweep FSM: visits each channel once per strobe; only the current channel's state is touched
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    ptr_d = ptr_q;
    dur_d = dur_q;
    phase_d = phase_q;
    inst_d = inst_q;
    gate_d = gate_q;
    load_d = '0;
    busy_d = busy_q;
    ovr_d = i_note_stb && busy_q;
    pat_addr_d = pat_addr_q;
    note_addr_d = note_addr_q;
    adv = 1'b0;
    case (state_q)
      IDLE: if (i_note_stb) begin
        state_d = CHECK;
        ch_d = '0;
        busy_d = 1'b1;
      end
      CHECK: if (!i_ch_enable[ch_q]) begin
        gate_d[ch_q] = 1'b0;
        adv = 1'b1;
      end else if (dur_q[ch_q] != 5'd0) begin
        dur_d[ch_q] = dur_q[ch_q] - 5'd1;
        adv = 1'b1;
      end else begin
        pat_addr_d = {ch_q, ptr_q[ch_q]};
        state_d = PAT_REQ;
      end
      PAT_REQ: state_d = PAT_LATCH;
      PAT_LATCH: begin
        dur_d[ch_q] = i_pat_data[9:5];
        ptr_d[ch_q] = i_pat_data[0] ? '0 : ptr_q[ch_q] + 1'b1;
        inst_d[ch_q] = i_pat_data[4:1];
        if (pitch == 6'd0) begin
          phase_d[ch_q] = '0;
          gate_d[ch_q] = 1'b0;
          load_d[ch_q] = 1'b1;
          adv = 1'b1;
        end else begin
          note_addr_d = pitch;
          state_d = NOTE_REQ;
        end
      end
      NOTE_REQ: state_d = NOTE_LATCH;
      NOTE_LATCH: begin
        phase_d[ch_q] = i_note_data;
        gate_d[ch_q] = 1'b1;
        load_d[ch_q] = 1'b1;
        adv = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      state_d = last_ch ? IDLE : CHECK;
      ch_d = last_ch ? '0 : ch_q + 1'b1;
      busy_d = !last_ch;
    end
    if (i_restart) begin
      state_d = IDLE;
      ch_d = '0;
      ptr_d = '0;
      dur_d = '0;
      phase_d = '0;
      inst_d = '0;
      gate_d = '0;
      load_d = '0;
      busy_d = 1'b0;
      ovr_d = 1'b0;
      pat_addr_d = '0;
      note_addr_d = '0;
    end
  end
  // State and per-channel registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      ptr_q <= '0;
      dur_q <= '0;
      phase_q <= '0;
      inst_q <= '0;
      gate_q <= '0;
      load_q <= '0;
      busy_q <= 1'b0;
      ovr_q <= 1'b0;
      pat_addr_q <= '0;
      note_addr_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
      dur_q <= dur_d;
      phase_q <= phase_d;
      inst_q <= inst_d;
      gate_q <= gate_d;
      load_q <= load_d;
      busy_q <= busy_d;
      ovr_q <= ovr_d;
      pat_addr_q <= pat_addr_d;
      note_addr_q <= note_addr_d;
    end
  end
endmodule

// File: tb/tb_multi_channel_sequencer.sv
// tb_multi_channel_sequencer: directed-vector bench for the 4-channel sequencer with synchronous ROM models
module tb_multi_channel_sequencer;
  logic clk, rst, note_stb, restart;
  logic [3:0] ch_enable;
  logic [7:0] pat_addr;
  logic [15:0] pat_data;
  logic [5:0] note_addr;
  logic [15:0] note_data;
  logic [63:0] phase_delta;
  logic [15:0] instrument;
  logic [3:0] gate, load_stb;
  logic busy, overrun;
  logic [15:0] pat_mem [256];
  logic [15:0] note_mem [64];
  logic [7:0] pat_at_ch2;
  logic [5:0] note_at_ch1;
  int vectors = 0;
  int miscompares = 0;

  multi_channel_sequencer #(.NUM_CHANNELS(4), .PTR_W(6), .PHASE_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_note_stb(note_stb), .i_restart(restart),
    .i_ch_enable(ch_enable), .o_pat_addr(pat_addr), .i_pat_data(pat_data),
    .o_note_addr(note_addr), .i_note_data(note_data), .o_phase_delta(phase_delta),
    .o_instrument(instrument), .o_gate(gate), .o_load_stb(load_stb),
    .o_busy(busy), .o_overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pat_data <= pat_mem[pat_addr];
    note_data <= note_mem[note_addr];
  end

  function automatic logic [15:0] pw(input int p, input int l, input int i, input int e);
    return {p[5:0], l[4:0], i[3:0], e[0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sweep(input string tag, input bit extra, input logic [3:0] en,
                       input logic [63:0] eph, input logic [3:0] egate, input logic [15:0] einst,
                       input logic [3:0] eload, input int ecyc);
    int cyc, ovr;
    int ld [4];
    cyc = 0;
    ovr = 0;
    ld = '{default: 0};
    ch_enable = en;
    note_stb = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (overrun) ovr++;
      for (int c = 0; c < 4; c++) if (load_stb[c]) ld[c]++;
      if (load_stb[1]) note_at_ch1 = note_addr;
      if (load_stb[2]) pat_at_ch2 = pat_addr;
      note_stb = extra && k == 3;
    end
    chk($sformatf("%s phase", tag), phase_delta, eph);
    chk($sformatf("%s gate", tag), gate, egate);
    chk($sformatf("%s inst", tag), instrument, einst);
    for (int c = 0; c < 4; c++) chk($sformatf("%s load%0d", tag, c), ld[c], eload[c]);
    chk($sformatf("%s busy_cycles", tag), cyc, ecyc);
    chk($sformatf("%s overrun", tag), ovr, extra);
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s busy", tag), busy, 0);
    chk($sformatf("%s gate", tag), gate, 0);
    chk($sformatf("%s phase", tag), phase_delta, 0);
    chk($sformatf("%s inst", tag), instrument, 0);
    chk($sformatf("%s load", tag), load_stb, 0);
    chk($sformatf("%s pat_addr", tag), pat_addr, 0);
    chk($sformatf("%s note_addr", tag), note_addr, 0);
    chk($sformatf("%s overrun", tag), overrun, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pat_mem[i] = 16'h0;
    for (int i = 0; i < 64; i++) note_mem[i] = 16'(i * 16'h0111);
    note_mem[5] = 16'h1234;
    pat_mem[0] = pw(5, 2, 3, 0);
    pat_mem[1] = pw(7, 0, 4, 0);
    pat_mem[2] = pw(9, 0, 1, 1);
    pat_mem[64] = pw(0, 0, 6, 0);
    pat_mem[65] = pw(3, 0, 2, 1);
    pat_mem[128] = pw(10, 0, 5, 0);
    pat_mem[129] = pw(11, 0, 7, 1);
    pat_mem[192] = pw(12, 1, 8, 1);
    rst = 1'b1;
    note_stb = 1'b0;
    restart = 1'b0;
    ch_enable = 4'hf;
    pat_at_ch2 = '0;
    note_at_ch1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");
    sweep("s1", 0, 4'b1111, 64'h0CCC_0AAA_0000_1234, 4'b1101, 16'h8563, 4'b1111, 18);
    chk("s1 ch2_addr", pat_at_ch2, 8'h80);
    chk("s1 ch1_no_note_fetch", note_at_ch1, 6'd5);
    sweep("s2", 0, 4'b1111, 64'h0CCC_0BBB_0333_1234, 4'b1111, 16'h8723, 4'b0110, 12);
    chk("s2 ch2_addr", pat_at_ch2, 8'h81);
    sweep("s3", 0, 4'b1111, 64'h0CCC_0AAA_0000_1234, 4'b1101, 16'h8563, 4'b1110, 14);
    chk("s3 ch2_addr", pat_at_ch2, 8'h80);
    sweep("s4", 0, 4'b1111, 64'h0CCC_0BBB_0333_0777, 4'b1111, 16'h8724, 4'b0111, 16);
    chk("s4 ch2_addr", pat_at_ch2, 8'h81);
    sweep("s5_overrun", 1, 4'b1111, 64'h0CCC_0AAA_0000_0999, 4'b1101, 16'h8561, 4'b1111, 18);
    sweep("s6_ch2_off", 0, 4'b1011, 64'h0CCC_0AAA_0333_1234, 4'b1011, 16'h8523, 4'b0011, 12);
    sweep("s7_ch2_on", 0, 4'b1111, 64'h0CCC_0BBB_0000_1234, 4'b1101, 16'h8763, 4'b1110, 14);
    chk("s7 ch2_addr", pat_at_ch2, 8'h81);
    note_stb = 1'b1;
    @(negedge clk);
    note_stb = 1'b0;
    repeat (6) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk_zero("restart");
    repeat (25) @(negedge clk);
    chk("restart idle", busy, 0);
    sweep("s8", 0, 4'b1111, 64'h0CCC_0AAA_0000_1234, 4'b1101, 16'h8563, 4'b1111, 18);
    chk("s8 ch2_addr", pat_at_ch2, 8'h80);
    note_stb = 1'b1;
    @(negedge clk);
    note_stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("pat_req addr", pat_addr, 8'h41);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    sweep("s9", 0, 4'b1111, 64'h0CCC_0AAA_0000_1234, 4'b1101, 16'h8563, 4'b1111, 18);
    chk("s9 ch2_addr", pat_at_ch2, 8'h80);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
